// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration loader: default geometry of
// one tile memory bank and the loader FSM state encoding.
package clb_cfg_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;
  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FIN
  } state_t;

endpackage

// File: rtl/clb_config_loader.sv
// Streams a bitstream LSB-first into a CLB tile config memory bank,
// one bit write per cycle, from address 0 up to num_bits-1.
module clb_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_bits,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              enable,
  output logic [ADDR_W-1:0] address,
  output logic              data_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned     IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]  ONE_BIT  = (ADDR_W + 1)'(1);

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   counter;
  logic [ADDR_W:0]     remaining;
  logic [IDX_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shift_reg;
  logic                err_q;
  logic                nb_ok;
  logic                last_bit;
  logic                wr_fire;

  // Legal lengths are 1..2^ADDR_W: nonzero, and MSB set only with zero low bits.
  assign nb_ok    = (num_bits != '0) && !(num_bits[ADDR_W] && (|num_bits[ADDR_W-1:0]));
  assign last_bit = (remaining == ONE_BIT);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start && nb_ok) state_nx = LOAD;
      LOAD: begin
        if (abort)        state_nx = IDLE;
        else if (s_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        if (abort)                    state_nx = IDLE;
        else if (last_bit)            state_nx = FIN;
        else if (bit_idx == LAST_IDX) state_nx = LOAD;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Abort gates the current write, except the final one which is let through.
  always_comb begin
    wr_fire = (state == SHIFT) && (!abort || last_bit);
    s_ready = (state == LOAD);
    busy    = (state == LOAD) || (state == SHIFT);
    done    = (state == FIN);
    enable  = wr_fire;
    address = wr_fire ? counter : '0;
    data_in = wr_fire && shift_reg[bit_idx];
    err     = err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter   <= '0;
      remaining <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (nb_ok) begin
              counter   <= '0;
              remaining <= num_bits;
              err_q     <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            err_q <= 1'b1;
          end else if (s_valid) begin
            shift_reg <= s_data;
            bit_idx   <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            err_q <= 1'b1;
          end else begin
            remaining <= remaining - ONE_BIT;
            bit_idx   <= bit_idx + IDX_W'(1);
            // Hold the counter on the last write so it never wraps past 2^ADDR_W-1.
            if (!last_bit) counter <= counter + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Directed self-checking bench for clb_config_loader.
module tb_clb_config_loader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW:0]   num_bits;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          enable;
  logic [AW-1:0] address;
  logic          data_in;
  logic          busy;
  logic          done;
  logic          err;

  clb_config_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_bits(num_bits), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .enable(enable), .address(address),
    .data_in(data_in), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic mem [0:1023];
  int   wr_cnt    = 0;
  int   done_cnt  = 0;
  int   seq_bad   = 0;
  int   ld_wr     = 0;
  int   prev_addr = -1;

  // Write monitor: records every config write into a tile image.
  always @(negedge clk) begin
    if (enable) begin
      mem[address] = data_in;
      wr_cnt++;
      if (!(int'(address) == 0 || int'(address) == prev_addr + 1)) seq_bad++;
      prev_addr = int'(address);
      if (s_ready) ld_wr++;
    end
    if (done) done_cnt++;
  end

  logic [DW-1:0] words [$];

  int          r_wr, r_done, r_first_c, r_first_a;
  bit          r_busy_seen, r_timeout;
  logic        r_err_c1;
  logic [15:0] r_exit;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int nb, input int budget, input int gap_every,
                     input int abort_at, input int reset_at, input int restart_at);
    int widx = 0;
    int gap = 0;
    int nshift = 0;
    int w0 = wr_cnt;
    int d0 = done_cnt;
    bit hs;
    bit aborted = 0;
    bit resetted = 0;
    bit restarted = 0;
    r_first_c = -1; r_first_a = -1; r_busy_seen = 0; r_timeout = 1;
    r_err_c1 = 1'bx; r_exit = 'x;
    s_data = words[0];
    for (int c = 0; c < budget; c++) begin
      start = 0; abort = 0; reset = 1; num_bits = (AW+1)'(nb);
      if (c == 1) r_err_c1 = err;
      if (c > 0 && !busy) begin
        r_exit = {s_ready, enable, data_in, busy, done, err, address};
        r_timeout = 0;
        break;
      end
      if (busy) r_busy_seen = 1;
      if (enable && r_first_c < 0) begin r_first_c = c; r_first_a = int'(address); end
      if (busy && !s_ready) nshift++;
      if (c == 0) start = 1;
      if (abort_at > 0 && nshift == abort_at && !aborted) begin abort = 1; aborted = 1; end
      if (reset_at > 0 && nshift == reset_at && !resetted) begin reset = 0; resetted = 1; end
      if (restart_at > 0 && nshift == restart_at && !restarted) begin
        start = 1; num_bits = (AW+1)'(3); restarted = 1;
      end
      s_valid = (gap == 0);
      if (gap > 0) gap--;
      hs = s_ready && s_valid;
      step();
      if (hs) begin
        widx++;
        if (widx < words.size()) s_data = words[widx];
        if (gap_every > 0 && widx % gap_every == 0) gap = 5;
      end
    end
    check("timeout", r_timeout, 0);
    start = 0; abort = 0; reset = 1; s_valid = 0;
    step();
    r_wr = wr_cnt - w0;
    r_done = done_cnt - d0;
  endtask

  function automatic int bit_mismatches(input int n);
    int m = 0;
    logic [DW-1:0] w;
    for (int a = 0; a < n; a++) begin
      w = words[a / DW];
      if (mem[a] !== w[a % DW]) m++;
    end
    return m;
  endfunction

  initial begin
    reset = 0; start = 0; abort = 0; s_valid = 0; num_bits = '0; s_data = '0;
    step(); step();
    check("rst_s_ready", s_ready, 0);
    check("rst_enable", enable, 0);
    check("rst_address", address, 0);
    check("rst_data_in", data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1;
    step();
    check("post_rst_busy", busy, 0);

    // Two words, 10 bits: A5 then 03, s_valid held high
    words = '{8'hA5, 8'h03};
    run(10, 100, 0, 0, 0, 0);
    check("t1_writes", r_wr, 10);
    check("t1_done", r_done, 1);
    check("t1_first_cycle", r_first_c, 2);
    check("t1_first_addr", r_first_a, 0);
    check("t1_last_addr", prev_addr, 9);
    check("t1_bits", bit_mismatches(10), 0);
    check("t1_err", err, 0);

    // Out-of-range lengths
    run(0, 20, 0, 0, 0, 0);
    check("nb0_writes", r_wr, 0);
    check("nb0_busy", r_busy_seen, 0);
    check("nb0_err", err, 1);
    step(); step();
    check("nb0_err_sticky", err, 1);
    run(1025, 20, 0, 0, 0, 0);
    check("nb1025_writes", r_wr, 0);
    check("nb1025_busy", r_busy_seen, 0);
    check("nb1025_err", err, 1);

    // Abort on third SHIFT cycle
    words = '{8'h5A, 8'hC3, 8'h0F};
    run(20, 100, 0, 3, 0, 0);
    check("abort_writes", r_wr, 2);
    check("abort_done", r_done, 0);
    check("abort_err", err, 1);
    check("abort_busy", busy, 0);
    r_wr = wr_cnt;
    step(); step(); step();
    check("abort_quiet", wr_cnt - r_wr, 0);
    run(4, 100, 0, 0, 0, 0);
    check("restart_err_cleared", r_err_c1, 0);
    check("restart_writes", r_wr, 4);
    check("restart_done", r_done, 1);

    // Abort coincident with the final write
    run(3, 100, 0, 3, 0, 0);
    check("abort_last_writes", r_wr, 3);
    check("abort_last_done", r_done, 0);
    check("abort_last_err", err, 1);

    // Reset low for one cycle mid-SHIFT
    run(20, 100, 0, 0, 3, 0);
    check("rst_mid_outputs", r_exit, 0);
    check("rst_mid_done", r_done, 0);
    run(4, 100, 0, 0, 0, 0);
    check("rst_mid_new_addr", r_first_a, 0);
    check("rst_mid_new_writes", r_wr, 4);

    // start while busy is ignored
    words = '{8'hA5, 8'h03};
    run(10, 100, 0, 0, 0, 2);
    check("busy_start_writes", r_wr, 10);
    check("busy_start_done", r_done, 1);
    check("busy_start_bits", bit_mismatches(10), 0);

    // Full bank with s_valid gaps every third word
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back(DW'(i * 37 + 11));
    run(1024, 4000, 3, 0, 0, 0);
    check("full_writes", r_wr, 1024);
    check("full_done", r_done, 1);
    check("full_last_addr", prev_addr, 1023);
    check("full_bits", bit_mismatches(1024), 0);
    check("no_write_in_load", ld_wr, 0);
    check("addr_sequence", seq_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
